reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Parametrised register-busy scoreboard for the in-order pipeline. It generalises the fixed-width one-hot index decoders into a 2^IDX_W-entry tracker with a per-register count of outstanding writes. Decode queries it for RAW/WAW hazards and gets a stall. Issue and writeback update it every cycle.

Parameters:
IDX_W, 5, register index width; NREG = 2^IDX_W entries
NUM_SRC, 2, number of source operands checked per issue
CNT_W, 2, per-register outstanding-write counter width; max in flight = 2^CNT_W-1
BYPASS, 1, 1 = a writeback in the same cycle releases a source whose count is 1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
issue_valid  input  1  decode presents an instruction
issue_we  input  1  instruction writes a destination register
issue_dest  input  IDX_W  destination index
src_idx  input  NUM_SRC*IDX_W  packed source indices; slot k at [k*IDX_W +: IDX_W]
src_used  input  NUM_SRC  per-slot enable; an unused slot never stalls
issue_fire  output  1  issue_valid & ~stall; instruction accepted this cycle
stall  output  1  combinational hazard indication
wb_valid  input  1  writeback completes one outstanding write
wb_dest  input  IDX_W  writeback index
flush  input  1  discard all in-flight writes
busy_vec  output  NREG  registered; bit i = (cnt[i] != 0)

Behaviour:
- State: cnt[i], CNT_W bits, for i in 1..NREG-1. Index 0 is hardwired zero: never busy, and never incremented or decremented.
- Reset (sync): all cnt = 0, busy_vec = 0. stall and issue_fire follow from the inputs and cnt, so they are 0 when issue_valid = 0.
- One-hot decode: inc_oh = decode(issue_dest) gated by issue_fire & issue_we & (issue_dest != 0). dec_oh = decode(wb_dest) gated by wb_valid & (wb_dest != 0).
- Source hazard for slot k: src_used[k] & (src_idx_k != 0) & cnt[src_idx_k] != 0.
  - Exception when BYPASS=1: the hazard is cleared if wb_valid & wb_dest == src_idx_k & cnt == 1.
- Dest hazard: issue_we & issue_dest != 0 & cnt[issue_dest] == max & not (wb_valid & wb_dest == issue_dest).
- stall = issue_valid & (any source hazard | dest hazard). issue_fire = issue_valid & ~stall.
- Update per entry, next cycle:
  - inc & ~dec → +1
  - dec & ~inc → -1
  - both or neither → unchanged
- busy_vec is registered from the next-state value, so it reflects the counts with zero extra latency after the edge.
- Underflow: wb_valid to an entry with cnt = 0 leaves it at 0. The sim-only assertion fires.
- Overflow is impossible: the dest hazard stalls at max.
- flush:
  - Highest priority. All cnt go to 0 next cycle, and any same-cycle issue/wb update is dropped.
  - stall is still computed from the current cnt that cycle. issue_fire is forced 0 while flush is high.
- Reset overrides flush and all updates. Reset asserted mid-stream clears everything next edge.
- Latency: the query is combinational, with 1-cycle visibility of an issued write.

Test Plan:
- Reset, issue_valid=1 we=1 dest=5 → issue_fire=1. Next cycle busy_vec[5]=1 and cnt[5]=1.
- cnt[5]=1, issue src0=5 used → stall=1. Same cycle wb_dest=5 with BYPASS=1 → stall=0, fire=1, cnt[5]=0 next.
- Three issues to dest 7 with no wb → cnt[7]=3. A fourth issue to 7 stalls. The same fourth issue with wb_dest=7 → fire, cnt stays 3.
- Issue to dest 0 with src 0 → never stall, busy_vec[0]=0 throughout. wb to 0 has no effect.
- Simultaneous issue dest 9 and wb dest 9 with cnt[9]=2 → cnt[9] stays 2. Simultaneous issue dest 3 and wb dest 4 → cnt[3]+1, cnt[4]-1.
- Busy entries 2,6,31, then flush with issue_valid=1 → issue_fire=0, busy_vec=0 next cycle. Reset mid-sequence with wb active → all zero next cycle.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Decode/issue/writeback bundle for the register-busy scoreboard.
interface reg_scoreboard_if #(
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned NUM_SRC = 2
);
  localparam int unsigned NREG = 1 << IDX_W;

  logic                     issue_valid;
  logic                     issue_we;
  logic [IDX_W-1:0]         issue_dest;
  logic [NUM_SRC*IDX_W-1:0] src_idx;
  logic [NUM_SRC-1:0]       src_used;
  logic                     issue_fire;
  logic                     stall;
  logic                     wb_valid;
  logic [IDX_W-1:0]         wb_dest;
  logic                     flush;
  logic [NREG-1:0]          busy_vec;

  // Pipeline side: drives issue/writeback/flush, observes the result.
  modport master (
    output issue_valid, issue_we, issue_dest, src_idx, src_used,
    output wb_valid, wb_dest, flush,
    input  issue_fire, stall, busy_vec
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_we, issue_dest, src_idx, src_used,
    input  wb_valid, wb_dest, flush,
    output issue_fire, stall, busy_vec
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: per-register count of outstanding writes,
// combinational RAW/WAW stall for decode, updated by issue and writeback.
module reg_scoreboard #(
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned BYPASS  = 1
) (
  input logic              clk,
  input logic              reset,
  reg_scoreboard_if.slave  sb
);
  localparam int unsigned NREG = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;

  logic [IDX_W-1:0]   src_k [NUM_SRC];
  logic [NUM_SRC-1:0] src_haz;
  logic               dest_haz;
  logic               stall;
  logic               fire;
  logic [NREG-1:0]    inc_oh, dec_oh;

  // Unpack source slots.
  always_comb begin
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      src_k[k] = sb.src_idx[k*IDX_W +: IDX_W];
    end
  end

  // Hazard detection against the current counts.
  always_comb begin
    src_haz = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sb.src_used[k] && (src_k[k] != '0) && (cnt_q[src_k[k]] != '0)) begin
        src_haz[k] = 1'b1;
        // A write retiring this very cycle releases its last reader.
        if ((BYPASS != 0) && sb.wb_valid && (sb.wb_dest == src_k[k]) &&
            (cnt_q[src_k[k]] == CNT_ONE)) begin
          src_haz[k] = 1'b0;
        end
      end
    end
    dest_haz = sb.issue_we && (sb.issue_dest != '0) &&
               (cnt_q[sb.issue_dest] == CNT_MAX) &&
               !(sb.wb_valid && (sb.wb_dest == sb.issue_dest));
    stall = sb.issue_valid && ((|src_haz) || dest_haz);
    fire  = sb.issue_valid && !stall && !sb.flush;
  end

  // One-hot increment/decrement requests; entry 0 is never tracked.
  always_comb begin
    inc_oh = '0;
    dec_oh = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      inc_oh[i] = fire && sb.issue_we && (sb.issue_dest == IDX_W'(i));
      dec_oh[i] = sb.wb_valid && (sb.wb_dest == IDX_W'(i));
    end
  end

  // Next counts: flush clears, otherwise net +1/-1, saturating at zero.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0 || sb.flush) begin
        cnt_d[i] = '0;
      end else if (inc_oh[i] && !dec_oh[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_oh[i] && !inc_oh[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q <= busy_d;
    end
  end

  assign sb.stall      = stall;
  assign sb.issue_fire = fire;
  assign sb.busy_vec   = busy_q;

  // A writeback to an idle register means the pipeline lost track of a write.
  a_no_underflow : assert property (
    @(posedge clk) disable iff (reset)
      !sb.flush |-> ((dec_oh & ~inc_oh & ~busy_q) == '0)
  ) else $error("reg_scoreboard: writeback to idle register");
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned MAXC  = 3;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  int unsigned   m_cnt [32];
  logic [31:0]   exp_q [$];

  always #5 clk = ~clk;

  reg_scoreboard_if #(.IDX_W(IDX_W), .NUM_SRC(NSRC)) sb ();

  reg_scoreboard #(.IDX_W(IDX_W), .NUM_SRC(NSRC), .CNT_W(2), .BYPASS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic idle_inputs();
    sb.issue_valid = 0; sb.issue_we = 0; sb.issue_dest = '0;
    sb.src_idx = '0; sb.src_used = '0;
    sb.wb_valid = 0; sb.wb_dest = '0; sb.flush = 0;
  endtask

  // One cycle: drive, check combinational outputs against the model,
  // push the expected busy vector, clock, then pop and compare.
  task automatic cyc(input string tag, input logic iv, input logic we, input logic [4:0] dest,
                     input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                     input logic wv, input logic [4:0] wd, input logic fl);
    logic       es, ef, inc, dec;
    logic [4:0] s [2];
    sb.issue_valid = iv; sb.issue_we = we; sb.issue_dest = dest;
    sb.src_idx = {s1, s0}; sb.src_used = used;
    sb.wb_valid = wv; sb.wb_dest = wd; sb.flush = fl;
    #1;
    s[0] = s0; s[1] = s1;
    es = 0;
    for (int k = 0; k < 2; k++)
      if (used[k] && s[k] != 0 && m_cnt[s[k]] != 0 &&
          !(wv && wd == s[k] && m_cnt[s[k]] == 1)) es = 1;
    if (we && dest != 0 && m_cnt[dest] == MAXC && !(wv && wd == dest)) es = 1;
    es = es & iv;
    ef = iv & ~es & ~fl;
    check({tag, ".stall"}, 32'(sb.stall), 32'(es));
    check({tag, ".fire"}, 32'(sb.issue_fire), 32'(ef));
    if (fl) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      inc = ef && we && dest != 0;
      dec = wv && wd != 0;
      if (!(inc && dec && dest == wd)) begin
        if (inc) m_cnt[dest]++;
        if (dec && m_cnt[wd] > 0) m_cnt[wd]--;
      end
    end
    exp_q.push_back(model_busy());
    @(posedge clk); #1;
    check({tag, ".busy"}, sb.busy_vec, exp_q.pop_front());
  endtask

  initial begin
    logic [4:0] rd, rw, r0, r1;
    logic       wv;
    idle_inputs();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    check("rst.busy", sb.busy_vec, 32'h0);
    check("rst.stall", 32'(sb.stall), 32'h0);
    check("rst.fire", 32'(sb.issue_fire), 32'h0);

    // Issue to r5, then read it: stall, then bypass with same-cycle wb.
    cyc("d5", 1, 1, 5, 0, 0, 2'b00, 0, 0, 0);
    check("d5.bit", 32'(sb.busy_vec[5]), 32'h1);
    cyc("raw5", 1, 0, 0, 5, 0, 2'b01, 0, 0, 0);
    cyc("byp5", 1, 0, 0, 5, 0, 2'b01, 1, 5, 0);
    check("byp5.bit", 32'(sb.busy_vec[5]), 32'h0);
    // Unused slot pointing at a busy register must not stall.
    cyc("d6", 1, 1, 6, 0, 0, 2'b00, 0, 0, 0);
    cyc("unused6", 1, 0, 0, 0, 6, 2'b01, 0, 0, 0);
    cyc("src1_6", 1, 0, 0, 0, 6, 2'b10, 0, 0, 0);
    cyc("wb6", 0, 0, 0, 0, 0, 2'b00, 1, 6, 0);

    // Fill r7 to max, fourth write stalls, then fires with same-cycle wb.
    for (int n = 0; n < 3; n++) cyc("d7", 1, 1, 7, 0, 0, 2'b00, 0, 0, 0);
    check("d7.cnt3", 32'(m_cnt[7]), 32'd3);
    cyc("waw7", 1, 1, 7, 0, 0, 2'b00, 0, 0, 0);
    cyc("waw7wb", 1, 1, 7, 0, 0, 2'b00, 1, 7, 0);
    check("waw7wb.bit", 32'(sb.busy_vec[7]), 32'h1);
    for (int n = 0; n < 3; n++) cyc("drain7", 0, 0, 0, 0, 0, 2'b00, 1, 7, 0);

    // Register 0 is never tracked.
    cyc("r0", 1, 1, 0, 0, 0, 2'b11, 0, 0, 0);
    cyc("r0wb", 1, 1, 0, 0, 0, 2'b11, 1, 0, 0);
    check("r0.bit", 32'(sb.busy_vec[0]), 32'h0);

    // Simultaneous inc/dec on one entry and on different entries.
    cyc("d9a", 1, 1, 9, 0, 0, 2'b00, 0, 0, 0);
    cyc("d9b", 1, 1, 9, 0, 0, 2'b00, 0, 0, 0);
    cyc("d9wb9", 1, 1, 9, 0, 0, 2'b00, 1, 9, 0);
    check("d9.cnt2", 32'(m_cnt[9]), 32'd2);
    cyc("d4", 1, 1, 4, 0, 0, 2'b00, 0, 0, 0);
    cyc("d3wb4", 1, 1, 3, 0, 0, 2'b00, 1, 4, 0);
    check("d3wb4.bits", {30'h0, sb.busy_vec[4:3]}, 32'h1);

    // Busy 2, 6, 31 then flush with an issue presented.
    cyc("d2", 1, 1, 2, 0, 0, 2'b00, 0, 0, 0);
    cyc("d6b", 1, 1, 6, 0, 0, 2'b00, 0, 0, 0);
    cyc("d31", 1, 1, 31, 0, 0, 2'b00, 0, 0, 0);
    cyc("flush", 1, 1, 8, 2, 0, 2'b01, 0, 0, 1);
    check("flush.busy", sb.busy_vec, 32'h0);

    // Reset mid-stream with writeback active.
    cyc("pre_rst", 1, 1, 12, 0, 0, 2'b00, 0, 0, 0);
    cyc("pre_rst2", 1, 1, 13, 0, 0, 2'b00, 0, 0, 0);
    reset = 1;
    sb.wb_valid = 1; sb.wb_dest = 12; sb.issue_valid = 1; sb.issue_we = 1; sb.issue_dest = 14;
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    #1;
    check("midrst.busy", sb.busy_vec, 32'h0);

    // Random traffic; writebacks only target registers with writes pending.
    for (int n = 0; n < 300; n++) begin
      rd = 5'($urandom_range(0, 7));
      r0 = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      rw = 5'($urandom_range(0, 7));
      wv = ($urandom_range(0, 1) == 1) && (m_cnt[rw] != 0 || rw == 0);
      cyc("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, r0, r1,
          2'($urandom_range(0, 3)), wv, rw, ($urandom_range(0, 40) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
